// File: rtl/uart_loader_pkg.sv
// Shared command/reply codes and FSM state encoding for the serial boot loader.
package uart_loader_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] ACK      = 8'h06;
   localparam logic [7:0] NAK      = 8'h15;
   localparam logic [7:0] RSP_HALT = 8'h48;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 4'd0,
      L_AHI  = 4'd1,
      L_ALO  = 4'd2,
      L_LEN  = 4'd3,
      L_DATA = 4'd4,
      L_CSUM = 4'd5,
      G_AHI  = 4'd6,
      G_ALO  = 4'd7,
      RUN    = 4'd8,
      REPLY  = 4'd9
   } state_t;

   // States in which the inter-byte timeout is armed.
   function automatic logic in_frame(state_t s);
      return (s inside {L_AHI, L_ALO, L_LEN, L_DATA, L_CSUM, G_AHI, G_ALO});
   endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Bundles the loader's UART rx/tx, RAM write port and CPU control signals.
interface uart_loader_if #(
   parameter int addr_width = 9
);
   logic                  received;
   logic [7:0]            rx_byte;
   logic                  is_transmitting;
   logic [7:0]            tx_byte;
   logic                  transmit;
   logic [addr_width-1:0] l_waddr;
   logic [7:0]            l_dwrite;
   logic                  l_write_en;
   logic [addr_width-1:0] startaddr;
   logic                  cpu_start;
   logic                  cpu_running;
   logic                  halted;

   modport master (
      input  received, rx_byte, is_transmitting, halted,
      output tx_byte, transmit, l_waddr, l_dwrite, l_write_en,
             startaddr, cpu_start, cpu_running
   );

   modport slave (
      output received, rx_byte, is_transmitting, halted,
      input  tx_byte, transmit, l_waddr, l_dwrite, l_write_en,
             startaddr, cpu_start, cpu_running
   );
endinterface

// File: rtl/uart_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, flags the timeout-th one.
module loader_timeout #(
   parameter int timeout = 1200000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expired
);
   localparam int CW = $clog2(timeout + 1);

   logic [CW-1:0] count_reg;

   // A clear in the same cycle suppresses expiry, so an arriving byte always wins.
   assign expired = en && !clr && (count_reg == CW'(timeout - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr || !en) begin
         count_reg <= '0;
      end else if (!expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end
endmodule

// File: rtl/uart_loader.sv
// Serial boot monitor: loads program bytes into RAM, starts the CPU, reports halt.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int addr_width = 9,
   parameter int timeout    = 1200000
) (
   input  logic          clk,
   input  logic          rst,
   uart_loader_if.master bus
);
   state_t                state_reg;
   logic [7:0]            addr_hi_reg;
   logic [addr_width-1:0] addr_reg;
   logic [7:0]            len_reg;
   logic [7:0]            csum_reg;
   logic [7:0]            reply_reg;
   logic                  go_pending_reg;
   logic [7:0]            tx_byte_reg;
   logic                  transmit_reg;
   logic [addr_width-1:0] l_waddr_reg;
   logic [7:0]            l_dwrite_reg;
   logic                  l_write_en_reg;
   logic [addr_width-1:0] startaddr_reg;
   logic                  cpu_start_reg;
   logic                  cpu_running_reg;
   logic                  expired;
   logic [15:0]           full_addr;

   assign full_addr = {addr_hi_reg, bus.rx_byte};

   loader_timeout #(.timeout(timeout)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .en      (in_frame(state_reg)),
      .clr     (bus.received),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         addr_hi_reg     <= '0;
         addr_reg        <= '0;
         len_reg         <= '0;
         csum_reg        <= '0;
         reply_reg       <= '0;
         go_pending_reg  <= 1'b0;
         tx_byte_reg     <= '0;
         transmit_reg    <= 1'b0;
         l_waddr_reg     <= '0;
         l_dwrite_reg    <= '0;
         l_write_en_reg  <= 1'b0;
         startaddr_reg   <= '0;
         cpu_start_reg   <= 1'b0;
         cpu_running_reg <= 1'b0;
      end else begin
         transmit_reg   <= 1'b0;
         l_write_en_reg <= 1'b0;
         cpu_start_reg  <= 1'b0;
         if (expired) begin
            reply_reg <= NAK;
            state_reg <= REPLY;
         end else begin
            case (state_reg)
               IDLE: if (bus.received) begin
                  if (bus.rx_byte == CMD_LOAD)    state_reg <= L_AHI;
                  else if (bus.rx_byte == CMD_GO) state_reg <= G_AHI;
               end
               L_AHI: if (bus.received) begin
                  addr_hi_reg <= bus.rx_byte;
                  state_reg   <= L_ALO;
               end
               L_ALO: if (bus.received) begin
                  addr_reg  <= full_addr[addr_width-1:0];
                  state_reg <= L_LEN;
               end
               L_LEN: if (bus.received) begin
                  len_reg   <= bus.rx_byte;
                  csum_reg  <= bus.rx_byte;
                  state_reg <= (bus.rx_byte == 8'd0) ? L_CSUM : L_DATA;
               end
               L_DATA: if (bus.received) begin
                  l_waddr_reg    <= addr_reg;
                  l_dwrite_reg   <= bus.rx_byte;
                  l_write_en_reg <= 1'b1;
                  addr_reg       <= addr_reg + 1'b1;
                  csum_reg       <= csum_reg + bus.rx_byte;
                  len_reg        <= len_reg - 1'b1;
                  if (len_reg == 8'd1) state_reg <= L_CSUM;
               end
               L_CSUM: if (bus.received) begin
                  reply_reg <= (bus.rx_byte == csum_reg) ? ACK : NAK;
                  state_reg <= REPLY;
               end
               G_AHI: if (bus.received) begin
                  addr_hi_reg <= bus.rx_byte;
                  state_reg   <= G_ALO;
               end
               // startaddr settles one cycle ahead of the start pulse.
               G_ALO: if (go_pending_reg) begin
                  go_pending_reg  <= 1'b0;
                  cpu_start_reg   <= 1'b1;
                  cpu_running_reg <= 1'b1;
                  state_reg       <= RUN;
               end else if (bus.received) begin
                  startaddr_reg  <= full_addr[addr_width-1:0];
                  go_pending_reg <= 1'b1;
               end
               RUN: if (bus.halted) begin
                  cpu_running_reg <= 1'b0;
                  reply_reg       <= RSP_HALT;
                  state_reg       <= REPLY;
               end
               REPLY: if (!bus.is_transmitting) begin
                  tx_byte_reg  <= reply_reg;
                  transmit_reg <= 1'b1;
                  state_reg    <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign bus.tx_byte     = tx_byte_reg;
   assign bus.transmit    = transmit_reg;
   assign bus.l_waddr     = l_waddr_reg;
   assign bus.l_dwrite    = l_dwrite_reg;
   assign bus.l_write_en  = l_write_en_reg;
   assign bus.startaddr   = startaddr_reg;
   assign bus.cpu_start   = cpu_start_reg;
   assign bus.cpu_running = cpu_running_reg;
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial boot monitor that sits directly upstream of the CPU.
- Receives framed commands from the UART receiver and writes program bytes into RAM through the loader write port.
- Supplies the CPU start address and issues a one-cycle start pulse.
- Reports CPU halt back over the UART transmitter.
- Owns the RAM write port and the UART tx whenever the CPU is not running; the top level muxes those resources on cpu_running.

Parameters:
- addr_width, 9, RAM address width; must match the CPU.
- timeout, 1200000, inter-byte timeout in clk cycles while inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- received  in  1  one-cycle strobe: rx_byte valid
- rx_byte  in  8  received UART byte
- is_transmitting  in  1  UART tx busy
- tx_byte  out  8  byte to send
- transmit  out  1  one-cycle send strobe
- l_waddr  out  addr_width  RAM write address
- l_dwrite  out  8  RAM write data
- l_write_en  out  1  one-cycle RAM write strobe
- startaddr  out  addr_width  CPU start address
- cpu_start  out  1  one-cycle CPU start pulse (drives the CPU rst/go input)
- cpu_running  out  1  high from cpu_start until halted is seen
- halted  in  1  one-cycle CPU halt strobe

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous and active-high. It forces state IDLE and drives every output to 0 (including startaddr and cpu_running); the timeout counter clears. Reset mid-frame or mid-run aborts with no reply.
- Commands, byte-wise, in IDLE:
  - 'L' (0x4C), addr_hi, addr_lo, len, data[len], csum. Load frame.
  - 'G' (0x47), addr_hi, addr_lo. Go command.
  - Any other byte in IDLE is discarded silently.
- Address: {addr_hi,addr_lo} truncated to the low addr_width bits.
- States: IDLE, L_AHI, L_ALO, L_LEN, L_DATA, L_CSUM, G_AHI, G_ALO, RUN, REPLY.
- Load path:
  - Each data byte is written in the cycle after its received strobe: l_waddr=current address, l_dwrite=byte, l_write_en=1 for exactly one cycle.
  - The address then increments and wraps modulo 2^addr_width.
  - len=0: no data bytes; go straight to L_CSUM.
  - Checksum is the 8-bit sum of len and all data bytes, modulo 256. csum match -> reply ACK 0x06; mismatch -> NAK 0x15.
  - Data already written is not rolled back on NAK.
- Go path:
  - After addr_lo: startaddr latched.
  - Next cycle: cpu_start=1 for one cycle and cpu_running=1; enter RUN.
  - In RUN, received bytes are ignored (the CPU owns the UART) and the loader never transmits.
  - halted strobe in RUN: cpu_running=0, reply 'H' 0x48.
  - halted outside RUN is ignored.
- Timeout:
  - In any L_* or G_* state, a counter increments each cycle with no received strobe and clears on received.
  - On reaching timeout: reply NAK 0x15, then IDLE. No timeout in IDLE or RUN.
- REPLY:
  - Wait while is_transmitting=1.
  - First cycle with is_transmitting=0: tx_byte=reply, transmit=1 for one cycle, then IDLE.
  - received bytes during REPLY are dropped.
- Simultaneous events: received and timeout expiry in the same cycle -> the byte wins and the counter clears. The received strobe is assumed never back-to-back with fewer than 2 cycles between.
- Latency: RAM write 1 cycle after received. Reply request enters REPLY 1 cycle after the csum byte.

Decomposition:
- Shared package holds:
  - command codes CMD_LOAD=0x4C, CMD_GO=0x47;
  - reply codes ACK=0x06, NAK=0x15, RSP_HALT=0x48;
  - state localparams (4 bits).
- Natural sub-module: loader_timeout (counter with clear/enable/expired, parameter timeout).
- The checksum accumulator stays inline.

Test Plan:
- Load good frame: 4C 01 10 03 AA BB CC csum=0x34 -> writes AA@0x110, BB@0x111, CC@0x112 (addr_width=9), tx 0x06.
- Bad checksum: 4C 00 00 01 55 00 -> 55 written @0x000, tx 0x15, back in IDLE; next 'L' frame is accepted.
- Wrap and len=0: 4C 01 FF 02 11 22 35 -> 11@0x1FF, 22@0x000, ACK. Then 4C 00 00 00 00 -> no write, ACK.
- Go/halt: 47 00 20 -> startaddr=0x020, cpu_start pulse 1 cycle, cpu_running=1; bytes sent during RUN ignored. halted pulse -> cpu_running=0, tx 0x48.
- Timeout (timeout=100): 4C 00 then silence -> NAK 0x15 after 100 idle cycles, IDLE. Also: is_transmitting held high 50 cycles delays transmit until it drops.
- Async reset mid-L_DATA: rst asserted between clocks -> all outputs 0 immediately, no reply, next frame processed normally.
